// File: rtl/multi_cycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control FSM.
// Latency: n/a (types, constants and pure decode helpers only).
// Backpressure: n/a.
package multi_cycle_control_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_R_EXEC  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_I_EXEC  = 4'd9,
        S_JUMP    = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    // alu_op encoding shared with the single-cycle control
    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_RTYPE = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_BEQ   = 3'b100;
    localparam logic [2:0] ALU_BNE   = 3'b101;
    localparam logic [2:0] ALU_SLT   = 3'b110;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_JR     = 2'b11;

    localparam logic [1:0] RD_RT = 2'b00;
    localparam logic [1:0] RD_RD = 2'b01;
    localparam logic [1:0] RD_RA = 2'b10;

    localparam logic [1:0] M2R_ALU = 2'b00;
    localparam logic [1:0] M2R_MDR = 2'b01;
    localparam logic [1:0] M2R_PC  = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    // State following DECODE; S_TRAP marks an opcode we do not implement.
    function automatic state_t decode_target(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_RTYPE:                          return (fn == FN_JR) ? S_JUMP : S_R_EXEC;
            OP_J, OP_JAL:                      return S_JUMP;
            OP_BEQ, OP_BNE:                    return S_BRANCH;
            OP_LW, OP_SW:                      return S_MEM_ADR;
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: return S_I_EXEC;
            default:                           return S_TRAP;
        endcase
    endfunction

    // ALU operation for the immediate-arithmetic group
    function automatic logic [2:0] imm_alu_op(input logic [5:0] op);
        case (op)
            OP_ANDI: return ALU_AND;
            OP_ORI:  return ALU_OR;
            OP_SLTI: return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multi_cycle_control_mem_wait_timer.sv
// Counts memory wait cycles and flags the cycle in which the count reaches WAIT_LIMIT.
// Latency: expire is combinational from inc and the registered count.
// Backpressure: none; clr wins over inc, count saturates at WAIT_LIMIT.
module multi_cycle_control_mem_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic inc,
    output logic expire
);
    localparam int CW = $clog2(WAIT_LIMIT + 1);

    logic [CW-1:0] cnt;

    // wait counter: clear on request boundaries, count stalled request cycles
    always_ff @(posedge clk) begin
        if (!reset_n || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(WAIT_LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    // this stalled cycle is the one that brings the count to the limit
    assign expire = inc && (cnt >= CW'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM; optional trap state enabled by macro ILLEGAL_TRAP_EN.
// Latency: branch/jump 3, R/I-type/sw 4, lw 5 cycles plus one per memory wait cycle.
// Backpressure: FETCH/MEM_RD/MEM_WR hold until mem_ready; strobes forced low while reset_n=0.
module multi_cycle_control
    import multi_cycle_control_pkg::*;
#(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired,
    output logic             illegal_op,
    output logic             mem_timeout
);
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    state_t           state_q, state_d, dec_tgt;
    logic             rtype_q;
    logic [CNT_W-1:0] retired_q;
    logic             wait_clr, wait_inc, wait_expire, wait_trap;
    logic             is_bne, is_jr, is_illegal, next_is_mem;

    assign dec_tgt    = decode_target(opcode, funct);
    assign is_illegal = (dec_tgt == S_TRAP);
    assign is_bne     = (opcode == OP_BNE);
    assign is_jr      = (opcode == OP_RTYPE) && (funct == FN_JR);
    assign wait_trap  = TRAP_EN && wait_expire;
    assign next_is_mem = (state_d == S_FETCH) || (state_d == S_MEM_RD) || (state_d == S_MEM_WR);

    assign wait_inc = mem_req && !mem_ready;
    assign wait_clr = ((state_d != state_q) && next_is_mem) || (mem_req && mem_ready);

    multi_cycle_control_mem_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_mem_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (wait_clr),
        .inc     (wait_inc),
        .expire  (wait_expire)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_FETCH;
        else          state_q <= state_d;
    end

    // next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:   if (mem_ready) state_d = S_DECODE;
                       else if (wait_trap) state_d = S_TRAP;
            S_DECODE:  state_d = (is_illegal && !TRAP_EN) ? S_FETCH : dec_tgt;
            S_MEM_ADR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:  if (mem_ready) state_d = S_MEM_WB;
                       else if (wait_trap) state_d = S_TRAP;
            S_MEM_WR:  if (mem_ready) state_d = S_FETCH;
                       else if (wait_trap) state_d = S_TRAP;
            S_R_EXEC:  state_d = S_ALU_WB;
            S_I_EXEC:  state_d = S_ALU_WB;
            S_MEM_WB:  state_d = S_FETCH;
            S_ALU_WB:  state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            S_JUMP:    state_d = S_FETCH;
            S_TRAP:    state_d = TRAP_EN ? S_TRAP : S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    // output decode; write strobes are suppressed while reset is asserted
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_en      = 1'b0;
        pc_src     = PC_ALU;
        reg_write  = 1'b0;
        reg_dst    = RD_RT;
        mem_to_reg = M2R_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RT;
        alu_op     = ALU_ADD;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b  = SRCB_IMM_SH;
                instr_done = is_illegal && !TRAP_EN;
            end
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = M2R_MDR;
                instr_done = 1'b1;
            end
            S_MEM_WR: begin
                mem_req    = 1'b1;
                mem_we     = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_RTYPE;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = imm_alu_op(opcode);
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = rtype_q ? RD_RD : RD_RT;
                instr_done = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_op     = is_bne ? ALU_BNE : ALU_BEQ;
                pc_src     = PC_BRANCH;
                pc_en      = zero ^ is_bne;
                instr_done = 1'b1;
            end
            S_JUMP: begin
                pc_en      = 1'b1;
                instr_done = 1'b1;
                if (is_jr) begin
                    pc_src = PC_JR;
                end else begin
                    pc_src = PC_JUMP;
                    if (opcode == OP_JAL) begin
                        reg_write  = 1'b1;
                        reg_dst    = RD_RA;
                        mem_to_reg = M2R_PC;
                    end
                end
            end
            default: ;
        endcase
        if (!reset_n) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_en      = 1'b0;
            reg_write  = 1'b0;
            instr_done = 1'b0;
        end
    end

    // remember whether ALU_WB follows an R-type (rd) or an immediate op (rt)
    always_ff @(posedge clk) begin
        if (!reset_n)                  rtype_q <= 1'b0;
        else if (state_q == S_R_EXEC)  rtype_q <= 1'b1;
        else if (state_q == S_I_EXEC)  rtype_q <= 1'b0;
    end

    // retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (!reset_n)        retired_q <= '0;
        else if (instr_done) retired_q <= retired_q + CNT_W'(1);
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q, timeout_q;

    // sticky fault flags, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == S_DECODE && is_illegal) illegal_q <= 1'b1;
            if (wait_trap)                         timeout_q <= 1'b1;
        end
    end

    assign illegal_op  = illegal_q;
    assign mem_timeout = timeout_q;
`else
    assign illegal_op  = 1'b0;
    assign mem_timeout = 1'b0;
`endif

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed testbench for multi_cycle_control (CNT_W=4 so the retired wrap is reachable).
// Inputs driven 2-3 time units after the rising edge; outputs sampled there too.
// Runs both default and ILLEGAL_TRAP_EN builds.
module tb_multi_cycle_control;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [5:0]    opcode, funct;
    logic          zero, mem_ready;
    logic          mem_req, mem_we, i_or_d, ir_write, pc_en, reg_write;
    logic [1:0]    pc_src, reg_dst, mem_to_reg, alu_src_b;
    logic          alu_src_a, instr_done, illegal_op, mem_timeout;
    logic [2:0]    alu_op;
    logic [3:0]    state;
    logic [CW-1:0] retired;

    int nvec = 0;
    int nmis = 0;
    int exp_ret = 0;

    multi_cycle_control #(.WAIT_LIMIT(15), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
        .ir_write(ir_write), .pc_en(pc_en), .pc_src(pc_src), .reg_write(reg_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state), .instr_done(instr_done),
        .retired(retired), .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic z, input logic rdy);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    // FETCH with mem_ready high, then DECODE; leaves the bench in the third cycle
    task automatic fetch_decode(input string tag);
        check({tag, "_fetch"}, state, 0);
        check({tag, "_irw"}, ir_write, 1);
        check({tag, "_pcen_f"}, pc_en, 1);
        tick();
        check({tag, "_decode"}, state, 1);
        check({tag, "_srcb_d"}, alu_src_b, 2'b11);
        tick();
    endtask

    // last cycle of an instruction: done pulse, back to FETCH, counter stepped
    task automatic retire(input string tag);
        check({tag, "_done"}, instr_done, 1);
        tick();
        exp_ret = (exp_ret + 1) % 16;
        check({tag, "_to_fetch"}, state, 0);
        check({tag, "_retired"}, retired, exp_ret);
    endtask

    task automatic run_add(input string tag);
        drive(6'b000000, 6'b100000, 1'b0, 1'b1);
        fetch_decode(tag);
        check({tag, "_rexec"}, state, 6);
        tick();
        check({tag, "_aluwb"}, state, 7);
        retire(tag);
    endtask

    logic [5:0] iop  [4] = '{6'b001000, 6'b001100, 6'b001101, 6'b001010};
    logic [2:0] ialu [4] = '{3'b000, 3'b010, 3'b011, 3'b110};
    logic [5:0] bop  [4] = '{6'b000100, 6'b000100, 6'b000101, 6'b000101};
    logic       bz   [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic       bpc  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [2:0] balu [4] = '{3'b100, 3'b100, 3'b101, 3'b101};

    initial begin
        reset_n = 1'b0;
        drive(6'b0, 6'b0, 1'b0, 1'b0);
        tick(); tick();
        check("rst_state", state, 0);
        check("rst_retired", retired, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_illegal", illegal_op, 0);
        check("rst_timeout", mem_timeout, 0);

        // add: 0,1,6,7
        reset_n = 1'b1;
        drive(6'b000000, 6'b100000, 1'b0, 1'b1);
        check("add_memreq", mem_req, 1);
        check("add_srcb4", alu_src_b, 2'b01);
        fetch_decode("add");
        check("add_rexec", state, 6);
        check("add_srca", alu_src_a, 1);
        check("add_aluop", alu_op, 3'b001);
        check("add_srcb", alu_src_b, 2'b00);
        tick();
        check("add_aluwb", state, 7);
        check("add_rw", reg_write, 1);
        check("add_rdst", reg_dst, 2'b01);
        check("add_m2r", mem_to_reg, 2'b00);
        check("add_ret0", retired, 0);
        retire("add");

        // immediate group
        for (int i = 0; i < 4; i++) begin
            drive(iop[i], 6'b0, 1'b0, 1'b1);
            fetch_decode("itype");
            check("itype_state", state, 9);
            check("itype_aluop", alu_op, ialu[i]);
            check("itype_srcb", alu_src_b, 2'b10);
            tick();
            check("itype_wb", state, 7);
            check("itype_rdst", reg_dst, 2'b00);
            retire("itype");
        end

        // lw with three wait cycles in MEM_RD: 8 cycles total
        drive(6'b100011, 6'b0, 1'b0, 1'b1);
        fetch_decode("lw");
        check("lw_adr", state, 2);
        check("lw_adr_srcb", alu_src_b, 2'b10);
        mem_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("lw_wait_state", state, 3);
            check("lw_wait_iord", i_or_d, 1);
            check("lw_wait_rw", reg_write, 0);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("lw_rd_ready", state, 3);
        check("lw_rd_rw", reg_write, 0);
        tick();
        check("lw_wb", state, 4);
        check("lw_wb_rw", reg_write, 1);
        check("lw_wb_m2r", mem_to_reg, 2'b01);
        retire("lw");

        // sw with zero wait: 4 cycles
        drive(6'b101011, 6'b0, 1'b0, 1'b1);
        fetch_decode("sw");
        check("sw_adr", state, 2);
        tick();
        check("sw_wr", state, 5);
        check("sw_we", mem_we, 1);
        check("sw_iord", i_or_d, 1);
        retire("sw");

        // branches
        for (int i = 0; i < 4; i++) begin
            drive(bop[i], 6'b0, bz[i], 1'b1);
            fetch_decode("br");
            check("br_state", state, 8);
            check("br_pcen", pc_en, bpc[i]);
            check("br_pcsrc", pc_src, 2'b01);
            check("br_aluop", alu_op, balu[i]);
            retire("br");
        end

        // jal
        drive(6'b000011, 6'b0, 1'b0, 1'b1);
        fetch_decode("jal");
        check("jal_state", state, 10);
        check("jal_rw", reg_write, 1);
        check("jal_rdst", reg_dst, 2'b10);
        check("jal_m2r", mem_to_reg, 2'b10);
        check("jal_pcsrc", pc_src, 2'b10);
        check("jal_pcen", pc_en, 1);
        retire("jal");

        // jr
        drive(6'b000000, 6'b001000, 1'b0, 1'b1);
        fetch_decode("jr");
        check("jr_state", state, 10);
        check("jr_pcsrc", pc_src, 2'b11);
        check("jr_rw", reg_write, 0);
        retire("jr");

        // j
        drive(6'b000010, 6'b0, 1'b0, 1'b1);
        fetch_decode("j");
        check("j_pcsrc", pc_src, 2'b10);
        check("j_rw", reg_write, 0);
        retire("j");

        // illegal opcode
        drive(6'b111111, 6'b0, 1'b0, 1'b1);
        check("ill_fetch", state, 0);
        tick();
        check("ill_decode", state, 1);
`ifdef ILLEGAL_TRAP_EN
        check("ill_nodone", instr_done, 0);
        tick();
        check("ill_trap", state, 11);
        check("ill_flag", illegal_op, 1);
        tick(); tick();
        check("ill_trap_hold", state, 11);
        check("ill_flag_hold", illegal_op, 1);
        check("ill_trap_memreq", mem_req, 0);
        reset_n = 1'b0;
        tick();
        check("ill_rst_flag", illegal_op, 0);
        reset_n = 1'b1;
        exp_ret = 0;
`else
        check("ill_nop_done", instr_done, 1);
        check("ill_flag0", illegal_op, 0);
        tick();
        exp_ret = (exp_ret + 1) % 16;
        check("ill_to_fetch", state, 0);
        check("ill_retired", retired, exp_ret);
`endif

        // mem_ready held low in FETCH
        drive(6'b000000, 6'b100000, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 14; i++) tick();
        check("to_still_fetch", state, 0);
        check("to_flag_early", mem_timeout, 0);
        tick();
        check("to_trap", state, 11);
        check("to_flag", mem_timeout, 1);
        check("to_trap_memreq", mem_req, 0);
        reset_n = 1'b0;
        tick();
        check("to_rst_flag", mem_timeout, 0);
        reset_n = 1'b1;
        exp_ret = 0;
`else
        for (int i = 0; i < 20; i++) tick();
        check("stall_fetch", state, 0);
        check("stall_timeout0", mem_timeout, 0);
        check("stall_irw", ir_write, 0);
        check("stall_pcen", pc_en, 0);
        check("stall_memreq", mem_req, 1);
`endif
        run_add("stall_add");

        // retired counter wrap
        for (int i = 0; i < 16; i++) run_add("wrap");

        // reset during MEM_WR wait
        drive(6'b101011, 6'b0, 1'b0, 1'b1);
        fetch_decode("swr");
        check("swr_adr", state, 2);
        mem_ready = 1'b0;
        tick();
        check("swr_wr", state, 5);
        check("swr_we", mem_we, 1);
        check("swr_nodone", instr_done, 0);
        tick();
        check("swr_wr_hold", state, 5);
        reset_n = 1'b0; #1;
        check("swr_rst_we", mem_we, 0);
        tick();
        check("swr_rst_state", state, 0);
        check("swr_rst_retired", retired, 0);
        check("swr_rst_memreq", mem_req, 0);
        check("swr_rst_we2", mem_we, 0);
        check("swr_rst_rw", reg_write, 0);
        check("swr_rst_pcen", pc_en, 0);
        reset_n = 1'b1;
        exp_ret = 0;
        run_add("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
